// File: rtl/admo_divider_pkg.sv
// Operator encodings and decode helpers shared by the admo_divider slice.
// Operator codes are also exported as `ADMO_OP_* text macros for legacy users.
`ifndef ADMO_DEFS_SVH
`define ADMO_DEFS_SVH
`define ADMO_OP_DIV  2'b00
`define ADMO_OP_DIVU 2'b01
`define ADMO_OP_REM  2'b10
`define ADMO_OP_REMU 2'b11
`endif

package admo_divider_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = `ADMO_OP_DIV,
        OP_DIVU = `ADMO_OP_DIVU,
        OP_REM  = `ADMO_OP_REM,
        OP_REMU = `ADMO_OP_REMU
    } div_op_e;

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/admo_divider.sv
// Iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define ADMO_DIV_FAST_EN to short-circuit divide-by-zero and signed overflow.
module admo_divider
    import admo_divider_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] operand_a_i,
    input  logic [DATA_WIDTH-1:0] operand_b_i,
    input  logic [1:0]            operator_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    last_q;
    logic                    rem_sel_q;
    logic                    neg_quot_q;
    logic                    neg_rem_q;
    logic [DATA_WIDTH-1:0]   divisor_q;
    logic [DATA_WIDTH-1:0]   quot_q;
    logic [DATA_WIDTH-1:0]   rem_q;
    logic [DATA_WIDTH-1:0]   result_q;

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic                    a_neg;
    logic                    b_neg;
    logic                    b_zero;
    logic                    fast_hit;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   abs_a;
    logic [DATA_WIDTH-1:0]   abs_b;
    logic [DATA_WIDTH:0]     trial;
    logic                    step_ok;
    logic [DATA_WIDTH-1:0]   final_res;

    function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? (~v + DATA_WIDTH'(1)) : v;
    endfunction

    assign a_s    = operand_a_i;
    assign b_s    = operand_b_i;
    assign a_neg  = is_signed_op(operator_i) && (a_s < 0);
    assign b_neg  = is_signed_op(operator_i) && (b_s < 0);
    assign b_zero = (operand_b_i == '0);
    assign abs_a  = cond_neg(operand_a_i, a_neg);
    assign abs_b  = cond_neg(operand_b_i, b_neg);

`ifdef ADMO_DIV_FAST_EN
    logic ovf;
    assign ovf = is_signed_op(operator_i)
              && (operand_a_i == {1'b1, {(DATA_WIDTH-1){1'b0}}})
              && (operand_b_i == '1);
    assign fast_hit = b_zero || ovf;
`else
    assign fast_hit = 1'b0;
`endif

    assign accept  = (state_q == S_IDLE) && valid_i && !flush_i;
    assign ready_o = (state_q == S_IDLE);
    assign valid_o = (state_q == S_DONE);
    assign result_o = result_q;

    // Restoring step: a borrow out of the trial subtraction means the bit is 0.
    assign trial   = {rem_q, quot_q[DATA_WIDTH-1]} - {1'b0, divisor_q};
    assign step_ok = ~trial[DATA_WIDTH];

    // Divide-by-zero never negates the quotient so it stays all-ones.
    assign final_res = rem_sel_q ? cond_neg(rem_q, neg_rem_q)
                                 : cond_neg(quot_q, neg_quot_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept)  state_d = S_CALC;
            S_CALC:  if (last_q)  state_d = S_DONE;
            S_DONE:  if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // last_q marks the extra CALC cycle that applies signs and latches the result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q  <= fast_hit ? '0 : CNT_W'(DATA_WIDTH - 1);
                last_q <= fast_hit;
            end else if ((state_q == S_CALC) && !last_q) begin
                if (cnt_q == '0) begin
                    last_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            if ((state_q == S_CALC) && last_q && !flush_i) begin
                result_q <= final_res;
            end
        end
    end

    // Fast path preloads the magnitudes the full iteration would have produced.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rem_sel_q  <= is_rem_op(operator_i);
            neg_quot_q <= (a_neg ^ b_neg) && !b_zero;
            neg_rem_q  <= a_neg;
            divisor_q  <= abs_b;
            quot_q     <= (fast_hit && b_zero) ? '1 : abs_a;
            rem_q      <= (fast_hit && b_zero) ? abs_a : '0;
        end else if ((state_q == S_CALC) && !last_q) begin
            quot_q <= {quot_q[DATA_WIDTH-2:0], step_ok};
            rem_q  <= step_ok ? trial[DATA_WIDTH-1:0]
                              : {rem_q[DATA_WIDTH-2:0], quot_q[DATA_WIDTH-1]};
        end
    end

endmodule

// File: tb/tb_admo_divider.sv
// Scoreboard bench for admo_divider: reference model results are queued at
// request time and compared when valid_o rises.
module tb_admo_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] operand_a_i;
    logic [W-1:0] operand_b_i;
    logic [1:0]   operator_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    admo_divider #(.DATA_WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .operand_a_i(operand_a_i),
        .operand_b_i(operand_b_i),
        .operator_i (operator_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o)
    );

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic sgn;
        logic rem;
        sgn = (op == 2'b00) || (op == 2'b10);
        rem = op[1];
        if (b == '0) return rem ? a : '1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? '0 : a;
        if (sgn) return rem ? $signed(a) % $signed(b) : $signed(a) / $signed(b);
        return rem ? a % b : a / b;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b);
        logic sgn;
        sgn = (op == 2'b00) || (op == 2'b10);
`ifdef ADMO_DIV_FAST_EN
        if (b == '0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
        return sgn ? W + 1 : W + 1;
    endfunction

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, output bit ok);
        int n;
        n = 0;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = ready_o;
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        valid_i     = 1'b0;
        operand_a_i = $urandom;
        operand_b_i = $urandom;
        operator_i  = 2'($urandom_range(0, 3));
        if (ok) exp_q.push_back(model(op, a, b));
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready_o); end
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        n_tests++;
        if (result_o !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result_o); end
        rst_ni = 1'b1;
    endtask

    task automatic test_arith;
        logic [1:0]   ops [6] = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00};
        logic [W-1:0] av  [6] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd1000, 32'd77};
        logic [W-1:0] bv  [6] = '{32'd7, 32'd2, 32'd2, 32'd3, 32'd33, 32'hFFFF_FFF5};
        for (int i = 0; i < 6; i++) begin
            bit ok;
            int lat;
            logic [W-1:0] e;
            start_op(ops[i], av[i], bv[i], ok);
            wait_valid(lat);
            n_tests++;
            if (!ok || lat != exp_lat(ops[i], av[i], bv[i])) begin
                n_fail++;
                $display("FAIL arith_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(ops[i], av[i], bv[i]));
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (result_o !== e) begin n_fail++; $display("FAIL arith_result[%0d]: got %h expected %h", i, result_o, e); end
            @(posedge clk); #1;
            n_tests++;
            if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL arith_pulse[%0d]: got valid=%b ready=%b expected valid=0 ready=1", i, valid_o, ready_o);
            end
        end
    endtask

    task automatic test_special;
        logic [1:0]   ops [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
        logic [W-1:0] av  [6] = '{32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
        logic [W-1:0] bv  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            bit ok;
            int lat;
            logic [W-1:0] e;
            start_op(ops[i], av[i], bv[i], ok);
            wait_valid(lat);
            n_tests++;
            if (!ok || lat != exp_lat(ops[i], av[i], bv[i])) begin
                n_fail++;
                $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(ops[i], av[i], bv[i]));
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (result_o !== e) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, result_o, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold;
        bit ok;
        int lat;
        logic [W-1:0] e;
        ready_i = 1'b0;
        start_op(2'b01, 32'd100, 32'd7, ok);
        n_tests++;
        if (!ok || ready_o !== 1'b0) begin n_fail++; $display("FAIL hold_busy: got ready=%b expected 0", ready_o); end
        wait_valid(lat);
        n_tests++;
        if (lat != W + 1) begin n_fail++; $display("FAIL hold_latency: got %0d expected %0d", lat, W + 1); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (valid_o !== 1'b1 || result_o !== e || ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle[%0d]: got valid=%b result=%h ready=%b expected valid=1 result=%h ready=0",
                         i, valid_o, result_o, ready_o, e);
            end
            @(posedge clk); #1;
        end
        ready_i = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got valid=%b ready=%b expected valid=0 ready=1", valid_o, ready_o);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int lat;
        logic [W-1:0] e;
        start_op(2'b01, 32'd50, 32'd5, ok);
        wait_valid(lat);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (!ok || result_o !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", result_o, e); end
        operator_i  = 2'b01;
        operand_a_i = 32'd81;
        operand_b_i = 32'd9;
        valid_i     = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_no_bypass: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
        exp_q.push_back(model(2'b01, 32'd81, 32'd9));
        wait_valid(lat);
        n_tests++;
        if (lat != W + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, W + 1); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (result_o !== e) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", result_o, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush;
        bit ok;
        bit seen;
        int lat;
        logic [W-1:0] e;
        start_op(2'b01, 32'd100, 32'd7, ok);
        repeat (10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        n_tests++;
        if (!ok || ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got ready=%b valid=%b expected ready=1 valid=0", ready_o, valid_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got valid seen=%b expected 0", seen); end
        start_op(2'b01, 32'd9, 32'd3, ok);
        wait_valid(lat);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (!ok || lat != W + 1 || result_o !== e) begin
            n_fail++;
            $display("FAIL flush_after: got %h lat %0d expected %h lat %0d", result_o, lat, e, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int lat;
        logic [W-1:0] e;
        start_op(2'b01, 32'd100, 32'd7, ok);
        repeat (5) begin @(posedge clk); #1; end
        rst_ni = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        n_tests++;
        if (!ok || ready_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", ready_o); end
        n_tests++;
        if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", valid_o); end
        n_tests++;
        if (result_o !== '0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 0", result_o); end
        start_op(2'b01, 32'd1000, 32'd10, ok);
        wait_valid(lat);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_tests++;
        if (!ok || lat != W + 1 || result_o !== e) begin
            n_fail++;
            $display("FAIL rstmid_after: got %h lat %0d expected %h lat %0d", result_o, lat, e, W + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            bit ok;
            int lat;
            logic [1:0]   op;
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] e;
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(1, 15));
                1:       b = '0 - W'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = a >> $urandom_range(1, 8);
            endcase
            start_op(op, a, b, ok);
            wait_valid(lat);
            n_tests++;
            if (!ok || lat != exp_lat(op, a, b)) begin
                n_fail++;
                $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, exp_lat(op, a, b));
            end
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            n_tests++;
            if (result_o !== e) begin
                n_fail++;
                $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, result_o, e);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        valid_i     = 1'b0;
        ready_i     = 1'b1;
        operand_a_i = '0;
        operand_b_i = '0;
        operator_i  = 2'b00;
        test_reset;
        test_arith;
        test_special;
        test_hold;
        test_back_to_back;
        test_flush;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
